// File: rtl/cal_pkg.sv
// Shared calibration definitions: FSM state encodings and the
// power-on threshold/hysteresis defaults also used by the threshold detector.
// ADC_WIDTH normally comes from adc_config.v; 12 is used when it is absent.
`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif

package cal_pkg;

    localparam int ADC_WIDTH_DEF = `ADC_WIDTH;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_PUBLISH = 2'd3;

    // Mid-scale threshold and 1/16-scale hysteresis for a w-bit ADC.
    function automatic logic [31:0] def_threshold(input int w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] def_hysteresis(input int w);
        return 32'd1 << (w - 4);
    endfunction

endpackage

// File: rtl/toggle_detect.sv
// Converts a level-toggle strobe into a one-cycle pulse.
// Ports: clk, rst_n, i_toggle (strobe level), o_pulse (level differs from last cycle).
module toggle_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_toggle,
    output logic o_pulse
);

    logic r_level;

    // Stored level follows the input every cycle, whatever the caller's state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_level <= 1'b0;
        else        r_level <= i_toggle;
    end

    assign o_pulse = i_toggle ^ r_level;

endmodule

// File: rtl/threshold_calibrator.sv
// Collects windows of ADC samples, derives threshold = min + span/2 and
// hysteresis = span/8, and publishes them with a valid/ready handshake.
// Ports: clk, rst_n, enable, adc_value, adc_value_change (toggle strobe),
//        threshold, hysteresis, cfg_valid, cfg_ready, busy, cal_count.
module threshold_calibrator
    import cal_pkg::*;
#(
    parameter int ADC_WIDTH   = ADC_WIDTH_DEF,
    parameter int WINDOW_LOG2 = 13,
    parameter int MIN_SPAN    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [ADC_WIDTH-1:0] adc_value,
    input  logic                 adc_value_change,
    output logic [ADC_WIDTH-1:0] threshold,
    output logic [ADC_WIDTH-3:0] hysteresis,
    output logic                 cfg_valid,
    input  logic                 cfg_ready,
    output logic                 busy,
    output logic [7:0]           cal_count
);

    localparam int CW = WINDOW_LOG2 + 1;
    localparam logic [CW-1:0] WIN_N = {1'b1, {WINDOW_LOG2{1'b0}}};
    localparam logic [ADC_WIDTH-1:0] THR_RST =
        ADC_WIDTH'(def_threshold(ADC_WIDTH));
    localparam logic [ADC_WIDTH-3:0] HYS_RST =
        (ADC_WIDTH-2)'(def_hysteresis(ADC_WIDTH));

    logic [1:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [ADC_WIDTH-1:0] r_min;
    logic [ADC_WIDTH-1:0] r_max;
    logic [ADC_WIDTH-1:0] r_threshold;
    logic [ADC_WIDTH-3:0] r_hyst;
    logic                 r_valid;
    logic [7:0]           r_cal_count;

    logic                 w_pulse;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 w_last;
    logic [ADC_WIDTH-1:0] w_min_nxt;
    logic [ADC_WIDTH-1:0] w_max_nxt;
    logic [ADC_WIDTH-1:0] w_span;
    logic                 w_span_ok;
    logic [ADC_WIDTH-1:0] w_thr;
    logic [ADC_WIDTH-3:0] w_hyst;

    toggle_detect u_tdet (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_toggle (adc_value_change),
        .o_pulse  (w_pulse)
    );

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_last    = (w_cnt_nxt == WIN_N);
    assign w_min_nxt = (adc_value < r_min) ? adc_value : r_min;
    assign w_max_nxt = (adc_value > r_max) ? adc_value : r_max;

    // max >= min always holds after a full window, so no wrap here.
    assign w_span    = r_max - r_min;
    assign w_span_ok = {{(32-ADC_WIDTH){1'b0}}, w_span} >= 32'(MIN_SPAN);
    assign w_thr     = r_min + (w_span >> 1);
    assign w_hyst    = {1'b0, w_span[ADC_WIDTH-1:3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_min       <= '1;
            r_max       <= '0;
            r_threshold <= THR_RST;
            r_hyst      <= HYS_RST;
            r_valid     <= 1'b0;
            r_cal_count <= 8'd0;
        end else if (!enable) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_min   <= '1;
            r_max   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_cnt   <= '0;
                    r_min   <= '1;
                    r_max   <= '0;
                    r_state <= ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (w_pulse) begin
                        r_cnt <= w_cnt_nxt;
                        r_min <= w_min_nxt;
                        r_max <= w_max_nxt;
                        if (w_last) r_state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (w_span_ok) begin
                        r_threshold <= w_thr;
                        r_hyst      <= w_hyst;
                        r_valid     <= 1'b1;
                        r_state     <= ST_PUBLISH;
                    end else begin
                        r_cnt   <= '0;
                        r_min   <= '1;
                        r_max   <= '0;
                        r_state <= ST_ACQUIRE;
                    end
                end
                ST_PUBLISH: begin
                    if (r_valid && cfg_ready) begin
                        r_valid     <= 1'b0;
                        r_cal_count <= r_cal_count + 8'd1;
                        r_cnt       <= '0;
                        r_min       <= '1;
                        r_max       <= '0;
                        r_state     <= ST_ACQUIRE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign threshold  = r_threshold;
    assign hysteresis = r_hyst;
    assign cfg_valid  = r_valid;
    assign busy       = (r_state != ST_IDLE);
    assign cal_count  = r_cal_count;

endmodule
